// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions (package pipe_pkg): ALU select encodings,
// the packed EX/MEM control bundle and its bubble value.
package pipe_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLL  = 3'b011;
   localparam logic [2:0] ALU_SLLV = 3'b100;
   localparam logic [2:0] ALU_SRAV = 3'b101;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{reg_write: 1'b0, mem_read: 1'b0,
                                  mem_write: 1'b0, mem_to_reg: 1'b0};

   function automatic ctrl_t pack_ctrl(input logic rw, input logic mr,
                                       input logic mw, input logic mtr);
      ctrl_t c;
      c.reg_write  = rw;
      c.mem_read   = mr;
      c.mem_write  = mw;
      c.mem_to_reg = mtr;
      return c;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX bus: decoded ID fields and pipeline control in, registered EX fields out.
// The master side is the decode stage / environment, the slave side is id_ex_stage.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int SEL_W  = 3
) ();

   logic              Stall_in;
   logic              Flush;
   logic              ID_Valid;
   logic [SEL_W-1:0]  ID_ALUSel;
   logic [DATA_W-1:0] ID_ALUIn1;
   logic [DATA_W-1:0] ID_ALUIn2;
   logic [4:0]        ID_Shamt;
   logic [DATA_W-1:0] ID_StoreData;
   logic [REG_W-1:0]  ID_Rs;
   logic [REG_W-1:0]  ID_Rt;
   logic [REG_W-1:0]  ID_WriteReg;
   logic              ID_RegWrite;
   logic              ID_MemRead;
   logic              ID_MemWrite;
   logic              ID_MemToReg;

   logic              ID_Ready;
   logic              LoadUseStall;

   logic              EX_Valid;
   logic [SEL_W-1:0]  EX_ALUSel;
   logic [DATA_W-1:0] EX_ALUIn1;
   logic [DATA_W-1:0] EX_ALUIn2;
   logic [4:0]        EX_Shamt;
   logic [DATA_W-1:0] EX_StoreData;
   logic [REG_W-1:0]  EX_WriteReg;
   logic              EX_RegWrite;
   logic              EX_MemRead;
   logic              EX_MemWrite;
   logic              EX_MemToReg;

   modport master (
      output Stall_in, Flush, ID_Valid, ID_ALUSel, ID_ALUIn1, ID_ALUIn2,
             ID_Shamt, ID_StoreData, ID_Rs, ID_Rt, ID_WriteReg,
             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
      input  ID_Ready, LoadUseStall,
             EX_Valid, EX_ALUSel, EX_ALUIn1, EX_ALUIn2, EX_Shamt,
             EX_StoreData, EX_WriteReg,
             EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg
   );

   modport slave (
      input  Stall_in, Flush, ID_Valid, ID_ALUSel, ID_ALUIn1, ID_ALUIn2,
             ID_Shamt, ID_StoreData, ID_Rs, ID_Rt, ID_WriteReg,
             ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg,
      output ID_Ready, LoadUseStall,
             EX_Valid, EX_ALUSel, EX_ALUIn1, EX_ALUIn2, EX_Shamt,
             EX_StoreData, EX_WriteReg,
             EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg
   );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is a source of the ID
// instruction. Kept free of flush gating so the forwarding unit can reuse it.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             i_id_valid,
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_ex_valid,
   input  logic             i_ex_mem_read,
   input  logic [REG_W-1:0] i_ex_write_reg,
   output logic             o_hazard
);

   logic w_dest_live;
   logic w_src_match;

   // $0 is hardwired, so a load targeting it never creates a dependency.
   assign w_dest_live = i_ex_valid && i_ex_mem_read && (i_ex_write_reg != '0);
   assign w_src_match = (i_ex_write_reg == i_id_rs) || (i_ex_write_reg == i_id_rt);
   assign o_hazard    = i_id_valid && w_dest_live && w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use stall and bubble insertion.
// Optional macro PIPE_STATS_EN adds saturating BubbleCount/HoldCount outputs.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int SEL_W  = 3
) (
   input  logic        Clk,
   input  logic        Rst_n,
   id_ex_stage_if.slave bus
`ifdef PIPE_STATS_EN
   ,
   output logic [31:0] BubbleCount,
   output logic [31:0] HoldCount
`endif
);

   logic              r_ex_valid;
   logic [SEL_W-1:0]  r_ex_sel;
   logic [DATA_W-1:0] r_ex_in1;
   logic [DATA_W-1:0] r_ex_in2;
   logic [4:0]        r_ex_shamt;
   logic [DATA_W-1:0] r_ex_store;
   logic [REG_W-1:0]  r_ex_wr;
   ctrl_t             r_ex_ctrl;

   logic              w_hazard_raw;
   logic              w_load_use;
   logic              w_load_bubble;
   logic              w_load_id;
   ctrl_t             w_id_ctrl;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .i_id_valid     (bus.ID_Valid),
      .i_id_rs        (bus.ID_Rs),
      .i_id_rt        (bus.ID_Rt),
      .i_ex_valid     (r_ex_valid),
      .i_ex_mem_read  (r_ex_ctrl.mem_read),
      .i_ex_write_reg (r_ex_wr),
      .o_hazard       (w_hazard_raw)
   );

   // A flushed ID instruction is dead, so it cannot be stalled on.
   assign w_load_use = w_hazard_raw && !bus.Flush;

   assign w_load_bubble = bus.Flush
                       || (!bus.Stall_in && (w_load_use || !bus.ID_Valid));
   assign w_load_id     = !bus.Flush && !bus.Stall_in && !w_load_use && bus.ID_Valid;

   assign w_id_ctrl = pack_ctrl(bus.ID_RegWrite, bus.ID_MemRead,
                                bus.ID_MemWrite, bus.ID_MemToReg);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_ex_valid <= 1'b0;
         r_ex_sel   <= '0;
         r_ex_in1   <= '0;
         r_ex_in2   <= '0;
         r_ex_shamt <= '0;
         r_ex_store <= '0;
         r_ex_wr    <= '0;
         r_ex_ctrl  <= CTRL_NOP;
      end else if (w_load_bubble) begin
         r_ex_valid <= 1'b0;
         r_ex_sel   <= '0;
         r_ex_in1   <= '0;
         r_ex_in2   <= '0;
         r_ex_shamt <= '0;
         r_ex_store <= '0;
         r_ex_wr    <= '0;
         r_ex_ctrl  <= CTRL_NOP;
      end else if (w_load_id) begin
         r_ex_valid <= 1'b1;
         r_ex_sel   <= bus.ID_ALUSel;
         r_ex_in1   <= bus.ID_ALUIn1;
         r_ex_in2   <= bus.ID_ALUIn2;
         r_ex_shamt <= bus.ID_Shamt;
         r_ex_store <= bus.ID_StoreData;
         r_ex_wr    <= bus.ID_WriteReg;
         r_ex_ctrl  <= w_id_ctrl;
      end
   end

   assign bus.LoadUseStall = w_load_use;
   assign bus.ID_Ready     = !bus.Stall_in && !w_load_use;

   assign bus.EX_Valid     = r_ex_valid;
   assign bus.EX_ALUSel    = r_ex_sel;
   assign bus.EX_ALUIn1    = r_ex_in1;
   assign bus.EX_ALUIn2    = r_ex_in2;
   assign bus.EX_Shamt     = r_ex_shamt;
   assign bus.EX_StoreData = r_ex_store;
   assign bus.EX_WriteReg  = r_ex_wr;
   assign bus.EX_RegWrite  = r_ex_ctrl.reg_write;
   assign bus.EX_MemRead   = r_ex_ctrl.mem_read;
   assign bus.EX_MemWrite  = r_ex_ctrl.mem_write;
   assign bus.EX_MemToReg  = r_ex_ctrl.mem_to_reg;

`ifdef PIPE_STATS_EN
   logic [31:0] r_bubble_cnt;
   logic [31:0] r_hold_cnt;
   logic        w_count_bubble;
   logic        w_count_hold;

   // Only hazard-driven bubbles count; an empty ID slot is not a lost cycle.
   assign w_count_bubble = bus.Flush || (!bus.Stall_in && w_load_use);
   assign w_count_hold   = bus.Stall_in && !bus.Flush;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_bubble_cnt <= '0;
         r_hold_cnt   <= '0;
      end else begin
         if (w_count_bubble && (r_bubble_cnt != 32'hFFFF_FFFF))
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
         if (w_count_hold && (r_hold_cnt != 32'hFFFF_FFFF))
            r_hold_cnt <= r_hold_cnt + 32'd1;
      end
   end

   assign BubbleCount = r_bubble_cnt;
   assign HoldCount   = r_hold_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table with an EX-side scoreboard,
// plus hand-written async-reset sequences.
module tb_id_ex_stage;
   import pipe_pkg::*;

   typedef enum logic [1:0] {K_LOAD, K_HOLD, K_BUB} kind_e;

   typedef struct packed {
      logic        v;
      logic [2:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] sd;
      logic [4:0]  wr;
      logic [3:0]  ctrl;
   } ex_t;

   typedef struct packed {
      logic       stall;
      logic       flush;
      ex_t        id;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       lus;
      kind_e      kind;
   } vec_t;

   localparam logic [3:0] C_RW = 4'b1000;
   localparam logic [3:0] C_LW = 4'b1101;
   localparam logic [3:0] C_SW = 4'b0010;
   localparam int NV = 25;

   logic Clk;
   logic Rst_n;
   int   checks;
   int   errors;
   vec_t vecs [NV];
   ex_t  sb_q [$];
   ex_t  last_exp;
   ex_t  exp_e;
   ex_t  got_e;
   int   exp_bubbles;
   int   exp_holds;

   id_ex_stage_if #(.DATA_W(32), .REG_W(5), .SEL_W(3)) bus ();

`ifdef PIPE_STATS_EN
   logic [31:0] BubbleCount;
   logic [31:0] HoldCount;
   id_ex_stage dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus.slave),
                    .BubbleCount(BubbleCount), .HoldCount(HoldCount));
`else
   id_ex_stage dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus.slave));
`endif

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic vec_t row(input logic stall, input logic flush, input logic valid,
                                input logic [2:0] sel, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] sh,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] wr, input logic [3:0] ctrl,
                                input logic lus, input kind_e kind);
      vec_t r;
      r.stall   = stall;
      r.flush   = flush;
      r.id.v    = valid;
      r.id.sel  = sel;
      r.id.a    = a;
      r.id.b    = b;
      r.id.sh   = sh;
      r.id.sd   = a ^ (b << 4);
      r.id.wr   = wr;
      r.id.ctrl = ctrl;
      r.rs      = rs;
      r.rt      = rt;
      r.lus     = lus;
      r.kind    = kind;
      return r;
   endfunction

   function automatic ex_t get_ex();
      ex_t e;
      e.v    = bus.EX_Valid;
      e.sel  = bus.EX_ALUSel;
      e.a    = bus.EX_ALUIn1;
      e.b    = bus.EX_ALUIn2;
      e.sh   = bus.EX_Shamt;
      e.sd   = bus.EX_StoreData;
      e.wr   = bus.EX_WriteReg;
      e.ctrl = {bus.EX_RegWrite, bus.EX_MemRead, bus.EX_MemWrite, bus.EX_MemToReg};
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic chk_ex(input string name, input ex_t act, input ex_t req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual v=%0b sel=%0h a=%0h b=%0h sh=%0h sd=%0h wr=%0h ctrl=%b required v=%0b sel=%0h a=%0h b=%0h sh=%0h sd=%0h wr=%0h ctrl=%b",
                  name, act.v, act.sel, act.a, act.b, act.sh, act.sd, act.wr, act.ctrl,
                  req.v, req.sel, req.a, req.b, req.sh, req.sd, req.wr, req.ctrl);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.Stall_in     = v.stall;
      bus.Flush        = v.flush;
      bus.ID_Valid     = v.id.v;
      bus.ID_ALUSel    = v.id.sel;
      bus.ID_ALUIn1    = v.id.a;
      bus.ID_ALUIn2    = v.id.b;
      bus.ID_Shamt     = v.id.sh;
      bus.ID_StoreData = v.id.sd;
      bus.ID_Rs        = v.rs;
      bus.ID_Rt        = v.rt;
      bus.ID_WriteReg  = v.id.wr;
      {bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite, bus.ID_MemToReg} = v.id.ctrl;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_bubbles = 0;
      exp_holds = 0;
      last_exp = '0;

      vecs[0]  = row(0,0,1,ALU_ADD ,  5,  7,0, 1, 2, 8,C_RW,0,K_LOAD);
      vecs[1]  = row(0,0,1,ALU_ADD ,100,  4,0, 3, 0, 9,C_LW,0,K_LOAD);
      vecs[2]  = row(0,0,1,ALU_ADD , 11, 22,0, 9, 4,10,C_RW,1,K_BUB);
      vecs[3]  = row(0,0,1,ALU_ADD , 11, 22,0, 9, 4,10,C_RW,0,K_LOAD);
      vecs[4]  = row(0,0,1,ALU_ADD ,  1,  2,0, 5, 0, 0,C_LW,0,K_LOAD);
      vecs[5]  = row(0,0,1,ALU_ADD ,  3,  4,0, 0, 0,11,C_RW,0,K_LOAD);
      vecs[6]  = row(0,0,1,ALU_ADD ,  7,  8,0, 1, 0, 9,C_LW,0,K_LOAD);
      vecs[7]  = row(0,0,1,ALU_ADD ,  9, 10,0,10,11,12,C_RW,0,K_LOAD);
      vecs[8]  = row(0,0,1,ALU_ADD , 13, 14,0, 1, 0, 9,C_LW,0,K_LOAD);
      vecs[9]  = row(0,0,1,ALU_ADD , 15, 16,0, 9, 9,13,C_RW,1,K_BUB);
      vecs[10] = row(0,0,1,ALU_ADD , 15, 16,0, 9, 9,13,C_RW,0,K_LOAD);
      vecs[11] = row(0,0,1,ALU_SUB , 50, 20,0, 1, 2,14,C_RW,0,K_LOAD);
      vecs[12] = row(1,0,1,ALU_SLL ,  0,  2,4, 0, 2,15,C_RW,0,K_HOLD);
      vecs[13] = row(1,0,1,ALU_SLL ,  0,  2,4, 0, 2,15,C_RW,0,K_HOLD);
      vecs[14] = row(1,0,1,ALU_SLL ,  0,  2,4, 0, 2,15,C_RW,0,K_HOLD);
      vecs[15] = row(0,0,1,ALU_SLL ,  0,  2,4, 0, 2,15,C_RW,0,K_LOAD);
      vecs[16] = row(0,0,1,ALU_ADD , 17, 18,0, 1, 0, 9,C_LW,0,K_LOAD);
      vecs[17] = row(1,0,1,ALU_SRAV, 19, 20,0, 9, 3,16,C_RW,1,K_HOLD);
      vecs[18] = row(0,0,1,ALU_SRAV, 19, 20,0, 9, 3,16,C_RW,1,K_BUB);
      vecs[19] = row(0,0,1,ALU_SRAV, 19, 20,0, 9, 3,16,C_RW,0,K_LOAD);
      vecs[20] = row(0,0,1,ALU_ADD , 21, 22,0, 1, 0, 9,C_LW,0,K_LOAD);
      vecs[21] = row(1,1,1,ALU_ADD , 23, 24,0, 9, 9,17,C_RW,0,K_BUB);
      vecs[22] = row(0,0,0,ALU_ADD , 25, 26,0, 9, 9,18,C_RW,0,K_BUB);
      vecs[23] = row(1,0,1,ALU_SLLV, 27, 28,0, 9, 0,19,C_RW,0,K_HOLD);
      vecs[24] = row(0,0,1,ALU_ADD , 29, 30,0, 2, 3, 0,C_SW,0,K_LOAD);

      // Reset state
      Rst_n = 1'b0;
      drive('0);
      #2;
      chk_ex("reset_ex", get_ex(), '0);
      chk("reset_lus", 32'(bus.LoadUseStall), 32'd0);
      chk("reset_ready", 32'(bus.ID_Ready), 32'd1);
      #10 Rst_n = 1'b1;
      @(negedge Clk);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d_lus", i), 32'(bus.LoadUseStall), 32'(vecs[i].lus));
         chk($sformatf("v%0d_ready", i), 32'(bus.ID_Ready),
             32'(!vecs[i].stall && !vecs[i].lus));
         case (vecs[i].kind)
            K_LOAD:  exp_e = vecs[i].id;
            K_HOLD:  exp_e = last_exp;
            default: exp_e = '0;
         endcase
         if (vecs[i].kind == K_BUB && (vecs[i].flush || vecs[i].lus)) exp_bubbles++;
         if (vecs[i].stall && !vecs[i].flush) exp_holds++;
         last_exp = exp_e;
         sb_q.push_back(exp_e);
         @(posedge Clk);
         #1;
         got_e = get_ex();
         chk_ex($sformatf("v%0d_ex", i), got_e, sb_q.pop_front());
         $display("vec %0d stall=%0b flush=%0b lus=%0b ex_v=%0b ex_wr=%0d ex_a=%0d",
                  i, vecs[i].stall, vecs[i].flush, bus.LoadUseStall, got_e.v, got_e.wr, got_e.a);
         @(negedge Clk);
      end

`ifdef PIPE_STATS_EN
      chk("bubble_count", BubbleCount, 32'(exp_bubbles));
      chk("hold_count", HoldCount, 32'(exp_holds));
`endif

      // Async reset mid-cycle while EX holds a valid instruction
      drive(row(0,0,1,ALU_ADD,31,32,0,1,2,20,C_RW,0,K_LOAD));
      @(posedge Clk);
      #1;
      chk("pre_reset_valid", 32'(bus.EX_Valid), 32'd1);
      #2 Rst_n = 1'b0;
      #1;
      chk_ex("async_reset_ex", get_ex(), '0);
      $display("async reset: ex_v=%0b ex_wr=%0d", bus.EX_Valid, bus.EX_WriteReg);
`ifdef PIPE_STATS_EN
      chk("reset_bubble_count", BubbleCount, 32'd0);
      chk("reset_hold_count", HoldCount, 32'd0);
`endif
      @(negedge Clk);
      Rst_n = 1'b1;

      // Reset during a stalled load-use pair: no bubble may survive
      drive(row(0,0,1,ALU_ADD,33,34,0,1,0,9,C_LW,0,K_LOAD));
      @(negedge Clk);
      drive(row(1,0,1,ALU_ADD,35,36,0,9,4,21,C_RW,1,K_HOLD));
      #1;
      chk("stall_lus", 32'(bus.LoadUseStall), 32'd1);
      chk("stall_ready", 32'(bus.ID_Ready), 32'd0);
      Rst_n = 1'b0;
      #1;
      chk("rst_stall_lus", 32'(bus.LoadUseStall), 32'd0);
      chk("rst_stall_memread", 32'(bus.EX_MemRead), 32'd0);
      bus.Stall_in = 1'b0;
      #1 Rst_n = 1'b1;
      @(posedge Clk);
      #1;
      chk("post_reset_valid", 32'(bus.EX_Valid), 32'd1);
      chk("post_reset_wr", 32'(bus.EX_WriteReg), 32'd21);
      $display("reset mid-stall: ex_v=%0b ex_wr=%0d", bus.EX_Valid, bus.EX_WriteReg);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the execute-stage ALU; captures decoded operands, ALU select, shamt, destination and control bits each cycle and presents them registered to EX.
- Integrates load-use hazard detection; holds on downstream stall, inserts bubbles on branch flush or load-use hazard.
- Drives the ALU inputs (ALUSel, ALUIn1, ALUIn2, shamt) and forwards control to EX/MEM.

Parameters:
- DATA_W, 32, operand/data width
- REG_W, 5, register-address width
- SEL_W, 3, ALU select width

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Stall_in  input  1  downstream busy; hold stage contents
- Flush  input  1  branch taken; kill instruction in ID
- ID_Valid  input  1  ID holds a real instruction
- ID_ALUSel  input  SEL_W  decoded ALU operation
- ID_ALUIn1  input  DATA_W  register read data 1
- ID_ALUIn2  input  DATA_W  read data 2 or sign-extended immediate
- ID_Shamt  input  5  shift amount
- ID_StoreData  input  DATA_W  sw data
- ID_Rs, ID_Rt  input  REG_W  source register numbers
- ID_WriteReg  input  REG_W  destination register
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg  input  1 each  control bits
- ID_Ready  output  1  ID may advance (= !Stall_in && !LoadUseStall)
- LoadUseStall  output  1  hazard; IF/PC/IF-ID hold
- EX_Valid  output  1  registered valid
- EX_ALUSel, EX_ALUIn1, EX_ALUIn2, EX_Shamt, EX_StoreData, EX_WriteReg  output  per ID_ width  registered copies
- EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg  output  1 each  registered control

Behaviour:
- Reset (Rst_n low, async): every EX_* output 0 (EX_ALUSel 3'b000), EX_Valid 0; LoadUseStall and ID_Ready follow combinational equations from reset state (LoadUseStall 0).
- Latency: one cycle, ID to EX.
- LoadUseStall (combinational) = ID_Valid && EX_Valid && EX_MemRead && EX_WriteReg != 0 && (EX_WriteReg == ID_Rs || EX_WriteReg == ID_Rt) && !Flush.
- Per-edge priority, highest first:
  1. Flush: load bubble (EX_Valid 0, all control bits 0, data fields 0); overrides Stall_in.
  2. Stall_in: hold all registers unchanged.
  3. LoadUseStall: load bubble. Next cycle the load is out of EX, so the hazard clears and the held ID instruction loads. Exactly one bubble per load-use pair.
  4. Otherwise load all ID_* fields. If ID_Valid is 0, load a bubble.
- Bubble invariant: EX_Valid 0 implies EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg all 0.
- WriteReg 0 never raises a hazard.
- Rs and Rt both matching raises a single stall, not two.
- Reset asserted mid-stall: all state cleared immediately; no pending bubble survives.

Optional Feature:
- Macro PIPE_STATS_EN.
- Defined:
  - Adds outputs BubbleCount and HoldCount, 32 bits each, saturating at 32'hFFFFFFFF, cleared by reset.
  - BubbleCount increments on each edge that loads a bubble due to Flush or LoadUseStall.
  - HoldCount increments on each edge where Stall_in holds (and Flush is 0).
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Shared package pipe_pkg:
  - ALUSel constants: ALU_ADD 3'b010, ALU_SUB 3'b110, ALU_SLL 3'b011, ALU_SLLV 3'b100, ALU_SRAV 3'b101.
  - Packed control struct: RegWrite, MemRead, MemWrite, MemToReg.
  - NOP/bubble control constant.
- One sub-module, hazard_detect: the combinational load-use comparator, reused later by the forwarding unit.

Test Plan:
- Straight flow: add ID_ALUIn1=5, ID_ALUIn2=7, ALUSel 010, WriteReg 8 -> next cycle EX_ALUIn1=5, EX_ALUIn2=7, EX_Valid=1, EX_RegWrite=1.
- Load-use: lw writing $9 in EX, ID add with Rs=9 -> LoadUseStall=1, ID_Ready=0, bubble next cycle; the following cycle the add loads with EX_Valid=1.
- No-hazard load: lw writing $0, ID Rs=0 -> LoadUseStall=0; lw writing $9, ID Rs=10, Rt=11 -> no stall.
- Stall_in=1 for 3 cycles with a sub in EX -> EX outputs constant for 3 cycles, then next ID instruction loads.
- Flush=1 with Stall_in=1 and a valid ID instruction -> bubble loaded, EX_Valid=0, all control bits 0; with PIPE_STATS_EN, BubbleCount increments by 1.
- Rst_n driven low asynchronously mid-cycle while EX_Valid=1 -> all EX_* outputs 0 before the next clock edge.
